cordic_req_scheduler: RTL and testbench

- Shares one cordic_sin_cos core between NUM_REQ requesters, e.g. several phase/rotation consumers that each need Q8.16 sin/cos.
- Arbitrates incoming angle requests round-robin and sequences the core's start/ready handshake.
- Returns sin/cos tagged with the requester ID.
- Includes a watchdog so a stalled core cannot hang the requesters.

---
 rtl/cordic_req_scheduler_pkg.sv | 14 +
 rtl/cordic_req_scheduler_rr_arbiter.sv | 31 +++
 rtl/cordic_req_scheduler.sv | 133 +++++++++++++
 tb/tb_cordic_req_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_req_scheduler_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_pkg;

  localparam int ANGLE_W = 24;
  localparam int FRAC_W  = 16;

  typedef logic signed [ANGLE_W-1:0] q8_16_t;

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, BUSY, RESP} sched_state_t;

  localparam q8_16_t PI_Q      = 24'h03243F;
  localparam q8_16_t HALF_PI_Q = 24'h01921F;

endpackage

// File: rtl/cordic_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_id
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one cordic_sin_cos core between NUM_REQ requesters with round-robin
// arbitration, start/ready sequencing and a watchdog on the core handshake.
//   state | meaning
//   IDLE  | grant a requester, latch its angle and ID
//   ISSUE | one-cycle core_start, clear watchdog
//   ARM   | wait for core_ready low (rejects stale ready)
//   BUSY  | wait for core_ready high, capture results
//   RESP  | one-cycle response strobe
module cordic_req_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [ANGLE_W-1:0]         rsp_sin,
  output logic [ANGLE_W-1:0]         rsp_cos,
  output logic                       rsp_err,
  output logic                       core_start,
  output logic [ANGLE_W-1:0]         core_angle,
  input  logic                       core_ready,
  input  logic [ANGLE_W-1:0]         core_sin,
  input  logic [ANGLE_W-1:0]         core_cos,
  output logic                       busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t         state, state_nxt;
  logic [ID_W-1:0]      ptr, gnt_id, id_q;
  logic [NUM_REQ-1:0]   grant;
  q8_16_t               angle_q, sin_q, cos_q;
  logic                 err_q;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_last, done;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (grant),
    .gnt_id(gnt_id)
  );

  assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // Completion beats the watchdog when both land on the same cycle.
  assign done     = (state == BUSY) && core_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = ARM;
      end
      ARM: begin
        if (cnt_last)         state_nxt = RESP;
        else if (!core_ready) state_nxt = BUSY;
      end
      BUSY: begin
        if (core_ready || cnt_last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      id_q    <= '0;
      angle_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            angle_q <= req_angle[int'(gnt_id)*ANGLE_W +: ANGLE_W];
            id_q    <= gnt_id;
            ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        ISSUE: cnt <= '0;
        ARM, BUSY: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            sin_q <= core_sin;
            cos_q <= core_cos;
            err_q <= 1'b0;
          end else if (cnt_last) begin
            sin_q <= '0;
            cos_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id     = id_q;
  assign rsp_sin    = sin_q;
  assign rsp_cos    = cos_q;
  assign rsp_err    = err_q;
  assign core_angle = angle_q;

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Bench for cordic_req_scheduler: stub core with programmable latency, a
// transaction-level model checked every cycle, plus literal expectations.
module tb_cordic_req_scheduler;
  import cordic_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int T  = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*24-1:0] req_angle = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_err, core_start, core_ready, busy;
  logic [IW-1:0]   rsp_id;
  logic [23:0]     rsp_sin, rsp_cos, core_angle, core_sin, core_cos;

  cordic_req_scheduler #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_err(rsp_err),
    .core_start(core_start), .core_angle(core_angle), .core_ready(core_ready),
    .core_sin(core_sin), .core_cos(core_cos), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] trig(input logic [23:0] a, input bit cosine);
    real r, v;
    r = $itor($signed(a)) / 65536.0;
    v = (cosine ? $cos(r) : $sin(r)) * 65536.0;
    return 24'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  // Stub core: ready drops on start, rises lat cycles later and stays high.
  bit   stuck = 0;
  int   lat = 5;
  logic rdy;
  int   scnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy <= 1'b0; scnt <= 0; core_sin <= '0; core_cos <= '0;
    end else if (core_start) begin
      rdy <= 1'b0; scnt <= lat;
      core_sin <= trig(core_angle, 1'b0);
      core_cos <= trig(core_angle, 1'b1);
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) rdy <= 1'b1;
    end
  end
  assign core_ready = stuck | rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_near(input string name, input logic [23:0] act, input logic [23:0] exp, input int tol);
    int d;
    d = int'($signed(act - exp));
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h +/- %0h", name, act, exp, tol);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++)
      if (g == '0 && v[(p + k) % N]) g[(p + k) % N] = 1'b1;
    return g;
  endfunction

  // Transaction model: one outstanding op, response time from stub latency.
  bit              out = 0;
  int              acc_cyc, rsp_cyc, m_ptr = 0, n_start = 0, n_rsp = 0;
  logic [IW-1:0]   e_id;
  logic [23:0]     e_ang, e_sin, e_cos;
  bit              e_err;
  int              log_id[$];
  logic [23:0]     log_sin[$], log_cos[$];
  bit              log_err[$];

  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      out = 0;
      m_ptr = 0;
    end else begin
      eg = out ? '0 : rr_pick(req_valid, m_ptr);
      chk("req_ready", req_ready, eg);
      chk("core_start", core_start, out && cyc == acc_cyc + 1);
      chk("busy", busy, out && cyc > acc_cyc);
      chk("rsp_valid", rsp_valid, out && cyc == rsp_cyc);
      if (out && cyc > acc_cyc) chk("core_angle", core_angle, e_ang);
      if (core_start) n_start++;
      if (rsp_valid) begin
        n_rsp++;
        log_id.push_back(int'(rsp_id));
        log_sin.push_back(rsp_sin);
        log_cos.push_back(rsp_cos);
        log_err.push_back(rsp_err);
      end
      if (out && cyc == rsp_cyc) begin
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_sin", rsp_sin, e_sin);
        chk("rsp_cos", rsp_cos, e_cos);
        chk("rsp_err", rsp_err, e_err);
        out = 0;
      end
      if (eg != '0) begin
        for (int i = 0; i < N; i++) if (eg[i]) e_id = IW'(i);
        out = 1;
        acc_cyc = cyc;
        e_ang = req_angle[int'(e_id)*24 +: 24];
        m_ptr = (int'(e_id) + 1) % N;
        if (!stuck && lat <= T - 1) begin
          rsp_cyc = cyc + 3 + lat;
          e_err = 0;
          e_sin = trig(e_ang, 1'b0);
          e_cos = trig(e_ang, 1'b1);
        end else begin
          rsp_cyc = cyc + 2 + T;
          e_err = 1;
          e_sin = '0;
          e_cos = '0;
        end
      end
    end
  end

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [23:0] a);
    req_angle[i*24 +: 24] = a;
    req_valid[i] = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((req_valid != '0 || out) && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_budget", (req_valid != '0 || out), 0);
  endtask

  task automatic clear_log();
    log_id.delete(); log_sin.delete(); log_cos.delete(); log_err.delete();
  endtask

  initial begin
    int n_before;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_core_angle", core_angle, 0);
    chk("reset_rsp_sin", rsp_sin, 0);
    chk("reset_rsp_id", rsp_id, 0);
    reset = 1'b0;
    cycle();

    // all four valid from pointer 0
    lat = 4;
    set_req(0, 24'h000000);
    set_req(1, 24'h00C90F);
    set_req(2, HALF_PI_Q);
    set_req(3, PI_Q);
    drain(300);
    chk("all4_count", log_id.size(), 4);
    if (log_id.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("all4_order", log_id[k], k);
      chk_near("all4_sin0", log_sin[0], 24'h000000, 'h40);
      chk_near("all4_sin1", log_sin[1], 24'h00B505, 'h40);
      chk_near("all4_sin2", log_sin[2], 24'h010000, 'h40);
      chk_near("all4_sin3", log_sin[3], 24'h000000, 'h40);
    end

    // single requester 0 at pi/2
    clear_log();
    n_start = 0;
    set_req(0, HALF_PI_Q);
    drain(100);
    chk("single_starts", n_start, 1);
    chk("single_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      chk("single_id", log_id[0], 0);
      chk_near("single_sin", log_sin[0], 24'h010000, 'h40);
      chk_near("single_cos", log_cos[0], 24'h000000, 'h40);
      chk("single_err", log_err[0], 0);
    end

    // pointer at 2, then 0 and 3 together: 3 first
    set_req(1, 24'h00C90F);
    drain(100);
    clear_log();
    set_req(0, 24'h000100);
    set_req(3, 24'h000200);
    drain(200);
    chk("ptr_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      chk("ptr_first", log_id[0], 3);
      chk("ptr_second", log_id[1], 0);
    end

    // -pi/2 from requester 1
    clear_log();
    lat = 7;
    set_req(1, 24'hFE6DE1);
    drain(100);
    chk("neg_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      chk("neg_id", log_id[0], 1);
      chk_near("neg_sin", log_sin[0], 24'hFF0000, 'h40);
      chk_near("neg_cos", log_cos[0], 24'h000000, 'h40);
    end

    // ready on the watchdog's last cycle succeeds; one later times out
    clear_log();
    lat = T - 1;
    set_req(2, HALF_PI_Q);
    drain(200);
    lat = T;
    set_req(2, HALF_PI_Q);
    drain(200);
    chk("limit_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      chk("limit_ok_err", log_err[0], 0);
      chk_near("limit_ok_sin", log_sin[0], 24'h010000, 'h40);
      chk("limit_to_err", log_err[1], 1);
      chk("limit_to_sin", log_sin[1], 0);
    end

    // ready stuck high: ARM never exits
    clear_log();
    stuck = 1;
    set_req(3, PI_Q);
    drain(200);
    stuck = 0;
    chk("stuck_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      chk("stuck_err", log_err[0], 1);
      chk("stuck_sin", log_sin[0], 0);
      chk("stuck_cos", log_cos[0], 0);
    end

    // async reset in the middle of BUSY
    lat = 20;
    set_req(1, 24'h004000);
    repeat (6) cycle();
    chk("pre_reset_busy", busy, 1);
    n_before = n_rsp;
    #1 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_core_start", core_start, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    cycle();
    cycle();
    #2 reset = 1'b0;
    cycle();
    chk("dropped_no_rsp", n_rsp, n_before);
    clear_log();
    lat = 3;
    set_req(0, 24'h000400);
    set_req(2, 24'h000800);
    drain(200);
    chk("post_reset_count", log_id.size(), 2);
    if (log_id.size() == 2) chk("post_reset_first", log_id[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
